pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the 5-stage MIPS core with precise exceptions.
- Replaces the fixed per-stage latches with one generic block, instantiated at D/E, E/M and M/W.
- Carries payload, pc, delay-slot flag, register-write address, decode fields, Tnew and exception code.
- Adds stall-hold, flush-bubble, valid tracking, exception-code merging and a bubble counter, none of which the fixed latches have.

---
 rtl/pipe_stage_reg.sv | 186 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic inter-stage pipeline register with stall, flush, exception redirect and bubble count
//
// Purpose:
//   One register slice between two stages of the 5-stage MIPS core (D/E, E/M, M/W).
//   Carries the instruction's payload, pc, delay-slot flag, destination register,
//   decode fields, Tnew and ExcCode. Every output is a flop, so there is no
//   combinational path from any input to any output.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req               CP0 exception/interrupt redirect (highest priority after reset)
//   flush             replace this stage's contents with a bubble, keeping pc/bd
//   stall             hold every output
//   in_*              incoming instruction fields
//   local_exc         ExcCode raised by the producing stage
//   out_*             registered copies of the in_* fields
//   bubble_cnt        number of bubbles inserted since reset (wraps)

module pipe_stage_reg #(
  parameter int          DATA_W        = 96,
  parameter int          TNEW_W        = 2,
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC    = 32'h0000_4180,
  parameter bit          SQUASH_ON_EXC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_a3,
  input  logic [5:0]        in_op,
  input  logic [5:0]        in_func,
  input  logic [4:0]        in_rs,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [4:0]        in_exc,
  input  logic [4:0]        local_exc,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_a3,
  output logic [5:0]        out_op,
  output logic [5:0]        out_func,
  output logic [4:0]        out_rs,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [4:0]        out_exc,
  output logic [31:0]       bubble_cnt
);

  logic              valid_q,  valid_d;
  logic [31:0]       pc_q,     pc_d;
  logic              bd_q,     bd_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [4:0]        a3_q,     a3_d;
  logic [5:0]        op_q,     op_d;
  logic [5:0]        func_q,   func_d;
  logic [4:0]        rs_q,     rs_d;
  logic [TNEW_W-1:0] tnew_q,   tnew_d;
  logic [4:0]        exc_q,    exc_d;
  logic [31:0]       bubble_cnt_q, bubble_cnt_d;

  logic [4:0]        merged_exc;
  logic              squash;
  logic              advance_bubble;

  // The earliest stage's exception wins: an inherited code masks the local one.
  assign merged_exc     = (in_exc != 5'd0) ? in_exc : local_exc;
  assign squash         = SQUASH_ON_EXC && (merged_exc != 5'd0);
  assign advance_bubble = !in_valid;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    bd_d         = bd_q;
    data_d       = data_q;
    a3_d         = a3_q;
    op_d         = op_q;
    func_d       = func_q;
    rs_d         = rs_q;
    tnew_d       = tnew_q;
    exc_d        = exc_q;
    bubble_cnt_d = bubble_cnt_q;

    if (req) begin
      valid_d = 1'b0;
      pc_d    = HANDLER_PC;
      bd_d    = 1'b0;
      data_d  = '0;
      a3_d    = '0;
      op_d    = '0;
      func_d  = '0;
      rs_d    = '0;
      tnew_d  = '0;
      exc_d   = '0;
    end else if (flush) begin
      // Bubble keeps pc/bd so a later exception still reports the right EPC.
      valid_d      = 1'b0;
      pc_d         = in_pc;
      bd_d         = in_bd;
      data_d       = '0;
      a3_d         = '0;
      op_d         = '0;
      func_d       = '0;
      rs_d         = '0;
      tnew_d       = '0;
      exc_d        = '0;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (!stall) begin
      valid_d = in_valid;
      pc_d    = in_pc;
      bd_d    = in_bd;
      if (advance_bubble) begin
        data_d       = '0;
        a3_d         = '0;
        op_d         = '0;
        func_d       = '0;
        rs_d         = '0;
        tnew_d       = '0;
        exc_d        = '0;
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
        data_d = in_data;
        exc_d  = merged_exc;
        // Saturating decrement: a ready result stays ready.
        tnew_d = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
        if (squash) begin
          a3_d   = '0;
          op_d   = '0;
          func_d = '0;
          rs_d   = '0;
        end else begin
          a3_d   = in_a3;
          op_d   = in_op;
          func_d = in_func;
          rs_d   = in_rs;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      bd_q         <= 1'b0;
      data_q       <= '0;
      a3_q         <= '0;
      op_q         <= '0;
      func_q       <= '0;
      rs_q         <= '0;
      tnew_q       <= '0;
      exc_q        <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      bd_q         <= bd_d;
      data_q       <= data_d;
      a3_q         <= a3_d;
      op_q         <= op_d;
      func_q       <= func_d;
      rs_q         <= rs_d;
      tnew_q       <= tnew_d;
      exc_q        <= exc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_bd     = bd_q;
  assign out_data   = data_q;
  assign out_a3     = a3_q;
  assign out_op     = op_q;
  assign out_func   = func_q;
  assign out_rs     = rs_q;
  assign out_tnew   = tnew_q;
  assign out_exc    = exc_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int TNEW_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, req, stall, flush, in_valid, in_bd;
  logic [31:0]       in_pc;
  logic [DATA_W-1:0] in_data;
  logic [4:0]        in_a3, in_rs, in_exc, local_exc;
  logic [5:0]        in_op, in_func;
  logic [TNEW_W-1:0] in_tnew;

  logic              out_valid, out_bd;
  logic [31:0]       out_pc, bubble_cnt;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_a3, out_rs, out_exc;
  logic [5:0]        out_op, out_func;
  logic [TNEW_W-1:0] out_tnew;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_data(in_data),
    .in_a3(in_a3), .in_op(in_op), .in_func(in_func), .in_rs(in_rs),
    .in_tnew(in_tnew), .in_exc(in_exc), .local_exc(local_exc),
    .out_valid(out_valid), .out_pc(out_pc), .out_bd(out_bd), .out_data(out_data),
    .out_a3(out_a3), .out_op(out_op), .out_func(out_func), .out_rs(out_rs),
    .out_tnew(out_tnew), .out_exc(out_exc), .bubble_cnt(bubble_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Behavioural model: what the stage must hold after each edge.
  logic              m_ok = 1'b0;
  logic              m_valid, m_bd;
  logic [31:0]       m_pc, m_cnt;
  logic [DATA_W-1:0] m_data;
  logic [4:0]        m_a3, m_rs, m_exc;
  logic [5:0]        m_op, m_func;
  int                m_tnew;
  logic              preset = 1'b0;   // bubble_cnt was forced to all-ones

  always @(posedge clk) begin
    logic [31:0] cnt;
    logic [4:0]  merged;
    cnt = preset ? 32'hFFFF_FFFF : m_cnt;
    if (reset) begin
      m_ok = 1'b1;
      m_pc = 32'h3000; m_valid = 0; m_bd = 0; m_data = '0; m_a3 = 0; m_op = 0;
      m_func = 0; m_rs = 0; m_tnew = 0; m_exc = 0; cnt = 0;
    end else if (req) begin
      m_pc = 32'h4180; m_valid = 0; m_bd = 0; m_data = '0; m_a3 = 0; m_op = 0;
      m_func = 0; m_rs = 0; m_tnew = 0; m_exc = 0;
    end else if (flush || (!stall && !in_valid)) begin
      m_pc = in_pc; m_bd = in_bd; m_valid = 0; m_data = '0; m_a3 = 0; m_op = 0;
      m_func = 0; m_rs = 0; m_tnew = 0; m_exc = 0;
      cnt = cnt + 1;
    end else if (!stall) begin
      merged  = (in_exc != 0) ? in_exc : local_exc;
      m_pc    = in_pc; m_bd = in_bd; m_valid = 1; m_data = in_data;
      m_tnew  = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
      m_exc   = merged;
      if (merged != 0) begin
        m_op = 0; m_func = 0; m_rs = 0; m_a3 = 0;
      end else begin
        m_op = in_op; m_func = in_func; m_rs = in_rs; m_a3 = in_a3;
      end
    end
    m_cnt = cnt;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("valid", 128'(out_valid), 128'(m_valid));
      check("pc",    128'(out_pc),    128'(m_pc));
      check("bd",    128'(out_bd),    128'(m_bd));
      check("data",  128'(out_data),  128'(m_data));
      check("a3",    128'(out_a3),    128'(m_a3));
      check("op",    128'(out_op),    128'(m_op));
      check("func",  128'(out_func),  128'(m_func));
      check("rs",    128'(out_rs),    128'(m_rs));
      check("tnew",  128'(out_tnew),  128'(m_tnew));
      check("exc",   128'(out_exc),   128'(m_exc));
      if (!preset) check("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(logic [31:0] pc, logic [5:0] op, logic [5:0] func, logic [4:0] rs,
                           logic [4:0] a3, logic [TNEW_W-1:0] tn, logic [4:0] ie, logic [4:0] le);
    in_valid = 1; in_pc = pc; in_bd = 0; in_op = op; in_func = func; in_rs = rs;
    in_a3 = a3; in_tnew = tn; in_exc = ie; local_exc = le;
    in_data = {pc, ~pc, pc ^ 32'h5A5A_A5A5};
  endtask

  initial begin
    reset = 1; req = 0; stall = 0; flush = 0;
    set_instr(32'h3004, 6'h00, 6'h21, 5'd1, 5'd2, 2'd2, 5'd0, 5'd0);

    // Reset held two cycles.
    cyc();
    check("rst_pc", 128'(out_pc), 128'(32'h3000));
    check("rst_valid", 128'(out_valid), 128'(0));
    cyc();
    check("rst_tnew", 128'(out_tnew), 128'(0));
    check("rst_cnt", 128'(bubble_cnt), 128'(0));
    reset = 0;
    cyc();
    check("first_pc", 128'(out_pc), 128'(32'h3004));
    check("first_tnew", 128'(out_tnew), 128'(1));
    check("first_valid", 128'(out_valid), 128'(1));

    // Exception merge and squash.
    set_instr(32'h3008, 6'h23, 6'h00, 5'd4, 5'd8, 2'd1, 5'd0, 5'd12);
    cyc();
    check("exc_local", 128'(out_exc), 128'(12));
    check("exc_op_sq", 128'(out_op), 128'(0));
    check("exc_a3_sq", 128'(out_a3), 128'(0));
    set_instr(32'h300C, 6'h23, 6'h00, 5'd4, 5'd8, 2'd1, 5'd4, 5'd12);
    cyc();
    check("exc_earliest", 128'(out_exc), 128'(4));

    // Stall holds everything, tnew included.
    set_instr(32'h3010, 6'h0D, 6'h00, 5'd7, 5'd9, 2'd3, 5'd0, 5'd0);
    cyc();
    check("pre_stall_tnew", 128'(out_tnew), 128'(2));
    check("pre_stall_op", 128'(out_op), 128'(6'h0D));
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(32'h3100 + 32'(i * 4), 6'h2B, 6'h00, 5'd3, 5'd6, 2'd0, 5'd0, 5'd0);
      cyc();
      check("stall_tnew", 128'(out_tnew), 128'(2));
      check("stall_pc", 128'(out_pc), 128'(32'h3010));
    end
    stall = 0;
    set_instr(32'h3200, 6'h08, 6'h00, 5'd5, 5'd10, 2'd1, 5'd0, 5'd0);
    cyc();
    check("post_stall_pc", 128'(out_pc), 128'(32'h3200));
    check("post_stall_a3", 128'(out_a3), 128'(10));

    // Flush beats stall.
    flush = 1; stall = 1;
    set_instr(32'h3010, 6'h08, 6'h00, 5'd5, 5'd10, 2'd2, 5'd0, 5'd0);
    in_bd = 1;
    cyc();
    check("flush_pc", 128'(out_pc), 128'(32'h3010));
    check("flush_bd", 128'(out_bd), 128'(1));
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_tnew", 128'(out_tnew), 128'(0));
    check("flush_cnt", 128'(bubble_cnt), 128'(1));

    // req beats flush and stall; reset beats req.
    req = 1;
    cyc();
    check("req_pc", 128'(out_pc), 128'(32'h4180));
    check("req_bd", 128'(out_bd), 128'(0));
    check("req_cnt", 128'(bubble_cnt), 128'(1));
    reset = 1;
    cyc();
    check("rst_req_pc", 128'(out_pc), 128'(32'h3000));
    check("rst_req_cnt", 128'(bubble_cnt), 128'(0));
    reset = 0; req = 0; flush = 0; stall = 0;

    // Invalid instruction advances as a counted bubble.
    set_instr(32'h3020, 6'h04, 6'h00, 5'd2, 5'd3, 2'd2, 5'd7, 5'd1);
    in_valid = 0; in_bd = 1;
    cyc();
    check("inv_pc", 128'(out_pc), 128'(32'h3020));
    check("inv_exc", 128'(out_exc), 128'(0));
    check("inv_cnt", 128'(bubble_cnt), 128'(1));

    // Counter wrap.
    preset = 1;
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    flush = 1;
    cyc();
    preset = 0;
    check("wrap_cnt", 128'(bubble_cnt), 128'(0));
    flush = 0;

    // Tnew saturates at zero.
    set_instr(32'h3030, 6'h00, 6'h20, 5'd1, 5'd2, 2'd0, 5'd0, 5'd0);
    cyc();
    check("tnew_sat", 128'(out_tnew), 128'(0));
    check("tnew_sat_func", 128'(out_func), 128'(6'h20));
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
